// File: rtl/img_pkg.sv
// Shared constants, FSM state encoding and frame-size helpers for the pixel frame store sequencer.
package img_pkg;

  localparam int HEIGHT_DEF = 30;
  localparam int WIDTH_DEF  = 30;
  localparam int BPP_DEF    = 3;
  localparam int FACTOR_DEF = 2;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_OUT  = 3'd4,
    DONE    = 3'd5
  } state_t;

  function automatic int n_full(input int h, input int w);
    return h * w;
  endfunction

  function automatic int n_shrink(input int h, input int w, input int f);
    return (h / f) * (w / f);
  endfunction

endpackage

// File: rtl/frame_buf_ctrl_if.sv
// Pixel-in stream, frame-store write/read ports and pixel-out stream of the frame buffer sequencer.
interface frame_buf_ctrl_if #(
  parameter int DW = 24,
  parameter int AW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    input  in_valid, in_data, mem_rd_data, out_ready,
    output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
    output mem_rd_en, mem_rd_addr, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, mem_rd_data, out_ready,
    input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  mem_rd_en, mem_rd_addr, out_valid, out_data
  );
endinterface

// File: rtl/pix_coord_cnt.sv
// Column/row position of the incoming pixel plus FACTOR phase counters that decide decimation keep.
module pix_coord_cnt
  import img_pkg::*;
#(
  parameter int FACTOR = FACTOR_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int WIDTH  = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic adv,
  input  logic shrink_mode,
  output logic keep,
  output logic last_pixel
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW = (FACTOR > 1) ? $clog2(FACTOR) : 1;

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic [PW-1:0] col_ph_reg;
  logic [PW-1:0] row_ph_reg;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_reg == CW'(WIDTH - 1));
  assign row_end = (row_reg == RW'(HEIGHT - 1));

  // Phase counters track col%FACTOR and row%FACTOR; they realign at every line wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg    <= '0;
      row_reg    <= '0;
      col_ph_reg <= '0;
      row_ph_reg <= '0;
    end else if (clr) begin
      col_reg    <= '0;
      row_reg    <= '0;
      col_ph_reg <= '0;
      row_ph_reg <= '0;
    end else if (adv) begin
      if (col_end) begin
        col_reg    <= '0;
        col_ph_reg <= '0;
        if (row_end) begin
          row_reg    <= '0;
          row_ph_reg <= '0;
        end else begin
          row_reg    <= row_reg + 1'b1;
          row_ph_reg <= (row_ph_reg == PW'(FACTOR - 1)) ? '0 : row_ph_reg + 1'b1;
        end
      end else begin
        col_reg    <= col_reg + 1'b1;
        col_ph_reg <= (col_ph_reg == PW'(FACTOR - 1)) ? '0 : col_ph_reg + 1'b1;
      end
    end
  end

  assign keep       = !shrink_mode || ((col_ph_reg == '0) && (row_ph_reg == '0));
  assign last_pixel = col_end && row_end;

endmodule

// File: rtl/frame_buf_ctrl.sv
// Frame sequencer: writes one (optionally decimated) frame into the store, then streams it back out.
module frame_buf_ctrl
  import img_pkg::*;
#(
  parameter int FACTOR = FACTOR_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int BPP    = BPP_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             shrink,
  output logic             busy,
  output logic             frame_done,
  frame_buf_ctrl_if.master bus
);

  localparam int DW       = 8 * BPP;
  localparam int N_FULL   = n_full(HEIGHT, WIDTH);
  localparam int N_SHRINK = n_shrink(HEIGHT, WIDTH, FACTOR);

  state_t            state_reg;
  logic              shrink_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [ADDR_W-1:0] last_addr_reg;
  logic              in_ready_reg;
  logic              rd_en_reg;
  logic              out_valid_reg;
  logic [DW-1:0]     out_data_reg;
  logic              busy_reg;
  logic              frame_done_reg;

  logic accept;
  logic keep;
  logic last_pixel;
  logic coord_clr;

  assign accept    = in_ready_reg && bus.in_valid;
  assign coord_clr = (state_reg == IDLE) && start;

  pix_coord_cnt #(
    .FACTOR (FACTOR),
    .HEIGHT (HEIGHT),
    .WIDTH  (WIDTH)
  ) u_coord (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (coord_clr),
    .adv         (accept),
    .shrink_mode (shrink_reg),
    .keep        (keep),
    .last_pixel  (last_pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      shrink_reg     <= 1'b0;
      wr_addr_reg    <= '0;
      rd_addr_reg    <= '0;
      last_addr_reg  <= '0;
      in_ready_reg   <= 1'b0;
      rd_en_reg      <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      rd_en_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= WRITE;
            shrink_reg    <= shrink;
            last_addr_reg <= shrink ? ADDR_W'(N_SHRINK - 1) : ADDR_W'(N_FULL - 1);
            wr_addr_reg   <= '0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        WRITE: begin
          if (accept) begin
            // Saturate so the address never points past the last stored pixel.
            if (keep && (wr_addr_reg != last_addr_reg)) begin
              wr_addr_reg <= wr_addr_reg + 1'b1;
            end
            if (last_pixel) begin
              state_reg    <= RD_REQ;
              in_ready_reg <= 1'b0;
              rd_addr_reg  <= '0;
              rd_en_reg    <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          state_reg <= RD_WAIT;
        end
        RD_WAIT: begin
          out_data_reg  <= bus.mem_rd_data;
          out_valid_reg <= 1'b1;
          state_reg     <= RD_OUT;
        end
        RD_OUT: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            if (rd_addr_reg == last_addr_reg) begin
              state_reg      <= DONE;
              frame_done_reg <= 1'b1;
            end else begin
              rd_addr_reg <= rd_addr_reg + 1'b1;
              rd_en_reg   <= 1'b1;
              state_reg   <= RD_REQ;
            end
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Write data is forced to zero outside the write window, one byte lane at a time.
  genvar gi;
  generate
    for (gi = 0; gi < BPP; gi++) begin : g_wr_lane
      assign bus.mem_wr_data[8*gi +: 8] = in_ready_reg ? bus.in_data[8*gi +: 8] : 8'h00;
    end
  endgenerate

  assign bus.in_ready    = in_ready_reg;
  assign bus.mem_wr_en   = accept && keep;
  assign bus.mem_wr_addr = wr_addr_reg;
  assign bus.mem_rd_en   = rd_en_reg;
  assign bus.mem_rd_addr = rd_addr_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_data    = out_data_reg;
  assign busy            = busy_reg;
  assign frame_done      = frame_done_reg;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Randomized bench for frame_buf_ctrl with a queue-based frame model and an attached frame store.
module tb_frame_buf_ctrl;
  import img_pkg::*;

  localparam int H  = 30;
  localparam int W  = 30;
  localparam int F  = 2;
  localparam int DW = 24;
  localparam int AW = 10;
  localparam int NF = H * W;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic shrink = 1'b0;
  logic busy;
  logic frame_done;

  always #5 clk = ~clk;

  frame_buf_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  frame_buf_ctrl #(
    .FACTOR (F), .HEIGHT (H), .WIDTH (W), .BPP (3), .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .shrink     (shrink),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  // Frame store with one-cycle registered read.
  logic [DW-1:0] store [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_wr_en) store[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= store[bus.mem_rd_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_hs = -1;
  int ready_mode = 0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  wr_t exp_wr[$];
  logic [DW-1:0] exp_out[$];
  logic [DW-1:0] pix [NF];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected store contents: the kept pixels in raster order, numbered consecutively.
  task automatic build_model(input bit shr, input bit rnd);
    int k;
    wr_t w;
    k = 0;
    exp_wr.delete();
    exp_out.delete();
    for (int i = 0; i < NF; i++) begin
      pix[i] = rnd ? DW'($urandom) : DW'(i);
      if (!shr || (((i / W) % F == 0) && ((i % W) % F == 0))) begin
        w.addr = AW'(k);
        w.data = pix[i];
        exp_wr.push_back(w);
        exp_out.push_back(pix[i]);
        k++;
      end
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    logic [DW-1:0] d;
    cyc++;
    if (rst_n) begin
      if (bus.mem_wr_en) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_extra actual addr=%0d data=%0h required no write", bus.mem_wr_addr, bus.mem_wr_data);
        end else begin
          e = exp_wr.pop_front();
          if (bus.mem_wr_addr !== e.addr || bus.mem_wr_data !== e.data) begin
            errors++;
            $display("FAIL wr actual addr=%0d data=%0h required addr=%0d data=%0h",
                     bus.mem_wr_addr, bus.mem_wr_data, e.addr, e.data);
          end
        end
      end
      if (bus.in_ready && !busy) begin
        checks++;
        errors++;
        $display("FAIL in_ready_idle actual=1 required=0");
      end
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
          errors++;
          $display("FAIL out_stable actual valid=%0b data=%0h required valid=1 data=%0h",
                   bus.out_valid, bus.out_data, prev_data);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_out.size() == 0) begin
          errors++;
          $display("FAIL out_extra actual=%0h required no output", bus.out_data);
        end else begin
          d = exp_out.pop_front();
          if (bus.out_data !== d) begin
            errors++;
            $display("FAIL out_data actual=%0h required=%0h", bus.out_data, d);
          end
        end
        if (ready_mode == 0 && last_hs >= 0) begin
          checks++;
          if (cyc - last_hs != 3) begin
            errors++;
            $display("FAIL rd_period actual=%0d required=3", cyc - last_hs);
          end
        end
        last_hs = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (frame_done) done_cnt++;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},        busy, 0);
    chk({tag, "_frame_done"},  frame_done, 0);
    chk({tag, "_in_ready"},    bus.in_ready, 0);
    chk({tag, "_mem_wr_en"},   bus.mem_wr_en, 0);
    chk({tag, "_mem_wr_addr"}, bus.mem_wr_addr, 0);
    chk({tag, "_mem_wr_data"}, bus.mem_wr_data, 0);
    chk({tag, "_mem_rd_en"},   bus.mem_rd_en, 0);
    chk({tag, "_mem_rd_addr"}, bus.mem_rd_addr, 0);
    chk({tag, "_out_valid"},   bus.out_valid, 0);
    chk({tag, "_out_data"},    bus.out_data, 0);
  endtask

  task automatic run_frame(input bit shr, input bit rnd, input bit gaps, input int rmode,
                           input bit inject, input int rst_at);
    int idx;
    int budget;
    int done0;
    bit inj_w;
    bit inj_r;
    idx = 0;
    inj_w = 1'b0;
    inj_r = 1'b0;
    build_model(shr, rnd);
    ready_mode = rmode;
    last_hs = -1;
    prev_stall = 1'b0;
    done0 = done_cnt;
    @(posedge clk); #1;
    shrink = shr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (inject) shrink = ~shr;
    budget = 0;
    while (idx < NF && budget < 20000) begin
      bus.in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.in_data  = pix[idx];
      start = inject && (idx >= 300) && !inj_w;
      if (start) inj_w = 1'b1;
      if (rst_at >= 0 && idx == rst_at) begin
        bus.in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        bus.in_valid = 1'b0;
        start = 1'b0;
        exp_wr.delete();
        exp_out.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_stall = 1'b0;
        $display("frame shr=%0b aborted by reset at pixel %0d", shr, idx);
        return;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
      budget++;
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    if (idx < NF) begin
      checks++; errors++;
      $display("FAIL write_timeout actual=%0d pixels required=%0d", idx, NF);
    end
    budget = 0;
    while (done_cnt == done0 && budget < 10000) begin
      @(posedge clk); #1;
      budget++;
      start = inject && bus.out_valid && !inj_r;
      if (start) inj_r = 1'b1;
    end
    start = 1'b0;
    if (done_cnt == done0) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no frame_done required=frame_done");
    end
    repeat (3) @(posedge clk);
    #1;
    chk("frame_done_count", done_cnt - done0, 1);
    chk("writes_left", exp_wr.size(), 0);
    chk("outputs_left", exp_out.size(), 0);
    chk("busy_after", busy, 0);
    $display("frame shr=%0b rnd=%0b gaps=%0b rmode=%0d inject=%0b done checks=%0d errors=%0d",
             shr, rnd, gaps, rmode, inject, checks, errors);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    build_model(1'b0, 1'b0);
    chk("model_full_len", exp_wr.size(), 900);
    chk("model_full_last", exp_wr[899].data, 899);
    build_model(1'b1, 1'b0);
    chk("model_shr_len", exp_wr.size(), 225);
    chk("model_shr_k16", exp_wr[16].data, 62);
    chk("model_shr_last_addr", exp_wr[224].addr, 224);
    chk("model_shr_last_data", exp_wr[224].data, 868);

    run_frame(1'b0, 1'b0, 1'b0, 0, 1'b0, -1);
    run_frame(1'b1, 1'b0, 1'b0, 0, 1'b0, -1);
    run_frame(1'b0, 1'b1, 1'b0, 1, 1'b0, -1);
    run_frame(1'b0, 1'b1, 1'b1, 2, 1'b0, -1);
    run_frame(1'b1, 1'b1, 1'b1, 0, 1'b1, -1);
    run_frame(1'b0, 1'b0, 1'b0, 0, 1'b0, 400);
    run_frame(1'b0, 1'b0, 1'b0, 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
